// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: request/grant bundle between four requesters and the mux-select arbiter.
//   req  [3:0] request vector, one bit per requester
//   gnt  [3:0] one-hot registered grant, zero when idle
//   S1, S0     mux select lines, {S1,S0} = index of granted requester
//   busy       high while any grant is active
//   master modport: arbiter side; slave modport: requester side.
interface mux4_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       S1;
    logic       S0;
    logic       busy;
    modport master (input req, output gnt, S1, S0, busy);
    modport slave  (output req, input gnt, S1, S0, busy);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter driving the select pins of a shared 4:1 mux.
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   arb_if  master modport: req in; gnt, S1, S0, busy out (all registered)
// Build option: define MUX_ARB_QUANTUM_EN to preempt an owner after QUANTUM
// consecutive grant cycles when another requester is waiting.
module mux4_rr_arbiter #(
    parameter int QUANTUM = 8,
    parameter int CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    mux4_rr_arbiter_if.master         arb_if
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0] cand;
    logic       found;
    logic [1:0] win;
    logic       at_q;
    logic       take;

    // Scan last+1, last+2, ... ; while granting, the owner is excluded so a
    // handoff always goes to someone else (offset 4 then never matches).
    always_comb begin
        cand = arb_if.req;
        if (state_q == GRANT) cand[last_q] = 1'b0;
        found = 1'b0;
        win   = last_q;
        for (int k = 4; k >= 1; k--) begin
            if (cand[last_q + 2'(k)]) begin
                found = 1'b1;
                win   = last_q + 2'(k);
            end
        end
    end

    assign at_q = (cnt_q == CNT_W'(QUANTUM - 1));

`ifdef MUX_ARB_QUANTUM_EN
    assign take = (state_q == IDLE) || !arb_if.req[last_q] || (at_q && found);
`else
    assign take = (state_q == IDLE) || !arb_if.req[last_q];
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (take) begin
            cnt_d = '0;
            if (found) begin
                state_d = GRANT;
                gnt_d   = 4'b0001 << win;
                sel_d   = win;
                last_d  = win;
            end else begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        end else begin
`ifdef MUX_ARB_QUANTUM_EN
            // Quantum expired with nobody waiting: owner keeps the mux, fresh quantum.
            cnt_d = at_q ? '0 : cnt_q + 1'b1;
`else
            cnt_d = at_q ? cnt_q : cnt_q + 1'b1;
`endif
        end
        busy_d = |gnt_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'b00;
            last_q  <= 2'd3;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign arb_if.gnt  = gnt_q;
    assign arb_if.S1   = sel_q[1];
    assign arb_if.S0   = sel_q[0];
    assign arb_if.busy = busy_q;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: vector table, hand sequences and randomized model comparison for mux4_rr_arbiter.
module tb_mux4_rr_arbiter;
    localparam int Q = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   total = 0;

    mux4_rr_arbiter_if bus ();

    mux4_rr_arbiter #(.QUANTUM(Q), .CNT_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .arb_if (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic step(input logic r, input logic [3:0] q);
        @(negedge clk);
        rst = r;
        bus.req = q;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic [3:0] g, input logic [1:0] s, input logic b);
        chk({name, " gnt"}, bus.gnt, g);
        chk({name, " sel"}, {2'b00, bus.S1, bus.S0}, {2'b00, s});
        chk({name, " busy"}, {3'b000, bus.busy}, {3'b000, b});
    endtask

    // Reference model: owner index (-1 when idle), rotation pointer, cycles in current tenure.
    int m_own, m_last, m_ten, m_sel;

    function automatic int scan(input logic [3:0] r, input int from, input int excl, input int n);
        for (int off = 1; off <= n; off++) begin
            int i;
            i = (from + off) % 4;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic m_grant(input int w);
        m_own = w;
        m_last = w;
        m_sel = w;
        m_ten = 1;
    endtask

    task automatic model(input logic r, input logic [3:0] q);
        int w;
        if (r) begin
            m_own = -1; m_last = 3; m_ten = 0; m_sel = 0;
        end else if (m_own < 0) begin
            w = scan(q, m_last, -1, 4);
            if (w >= 0) m_grant(w);
        end else if (!q[m_own]) begin
            w = scan(q, m_own, m_own, 3);
            if (w >= 0) m_grant(w);
            else m_own = -1;
        end else begin
`ifdef MUX_ARB_QUANTUM_EN
            if (m_ten == Q) begin
                w = scan(q, m_own, m_own, 3);
                if (w >= 0) m_grant(w);
                else m_ten = 1;
            end else m_ten++;
`else
            m_ten++;
`endif
        end
    endtask

    initial begin
        logic [3:0] r;
        logic [3:0] flip;
        logic       rr;
        logic [3:0] eg;
        bus.req = 4'b0000;

        tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 2'b00, 1'b0};
        tbl[1]  = '{1'b1, 4'b1111, 4'b0000, 2'b00, 1'b0};
        tbl[2]  = '{1'b0, 4'b1111, 4'b0001, 2'b00, 1'b1};
        tbl[3]  = '{1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0};
        tbl[4]  = '{1'b0, 4'b0100, 4'b0100, 2'b10, 1'b1};
        tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 2'b10, 1'b0};
        tbl[6]  = '{1'b0, 4'b0010, 4'b0010, 2'b01, 1'b1};
        tbl[7]  = '{1'b0, 4'b1001, 4'b1000, 2'b11, 1'b1};
        tbl[8]  = '{1'b0, 4'b1111, 4'b1000, 2'b11, 1'b1};
        tbl[9]  = '{1'b0, 4'b0111, 4'b0001, 2'b00, 1'b1};
        tbl[10] = '{1'b0, 4'b0110, 4'b0010, 2'b01, 1'b1};
        tbl[11] = '{1'b0, 4'b1111, 4'b0010, 2'b01, 1'b1};
        tbl[12] = '{1'b1, 4'b1111, 4'b0000, 2'b00, 1'b0};
        tbl[13] = '{1'b0, 4'b1111, 4'b0001, 2'b00, 1'b1};

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rst, tbl[i].req);
            chk_out($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].sel, tbl[i].busy);
        end

        // Rotation: each owner holds 3 cycles, drops, re-raises one cycle later.
        step(1'b1, 4'b1111);
        step(1'b0, 4'b1111);
        for (int t = 0; t < 5; t++) begin
            int o;
            o = t % 4;
            chk_out($sformatf("rot%0d start", t), 4'b0001 << o, 2'(o), 1'b1);
            step(1'b0, 4'b1111);
            chk_out($sformatf("rot%0d hold1", t), 4'b0001 << o, 2'(o), 1'b1);
            step(1'b0, 4'b1111);
            chk_out($sformatf("rot%0d hold2", t), 4'b0001 << o, 2'(o), 1'b1);
            r = 4'b1111;
            r[o] = 1'b0;
            step(1'b0, r);
        end

        // Quantum behaviour with two steady requesters.
        step(1'b1, 4'b0011);
        for (int c = 1; c <= 12; c++) begin
            step(1'b0, 4'b0011);
`ifdef MUX_ARB_QUANTUM_EN
            eg = (((c - 1) / Q) % 2 == 0) ? 4'b0001 : 4'b0010;
`else
            eg = 4'b0001;
`endif
            chk($sformatf("quantum c%0d gnt", c), bus.gnt, eg);
        end

        // Randomized run against the model.
        r = 4'b0000;
        step(1'b1, r);
        model(1'b1, r);
        for (int n = 0; n < 400; n++) begin
            flip = 4'b0000;
            for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 3) == 0);
            r = r ^ flip;
            rr = ($urandom_range(0, 63) == 0);
            step(rr, r);
            model(rr, r);
            eg = (m_own < 0) ? 4'b0000 : (4'b0001 << m_own);
            chk_out($sformatf("rnd%0d", n), eg, 2'(m_sel), m_own >= 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
